// File: rtl/scope_input_ctrl.sv
// -----------------------------------------------------------------------------
// scope_input_ctrl
//   Front-panel input conditioning for the scope: N_BTN push buttons plus one
//   quadrature rotary encoder with a push centre. Every pad is synchronised,
//   debounced, and turned into level/pulse outputs. The encoder drives a
//   bounded adjustment counter with fine (1) / coarse (STEP_COARSE) steps; the
//   centre press toggles the step mode.
//
// Ports
//   CLK_50M     in   1       single clock
//   RST_N       in   1       asynchronous assert, synchronised release, active-low
//   BTN         in   N_BTN   raw button pads, active-high
//   ROT_A/ROT_B in   1       raw encoder phases
//   ROT_CENTER  in   1       raw encoder push, active-high
//   BTN_LEVEL   out  N_BTN   debounced button state
//   BTN_PRESS   out  N_BTN   one-cycle pulse on each debounced 0->1
//   ROT_COUNT   out  CNT_W   adjustment value, 0..CNT_MAX
//   ROT_UP      out  1       one-cycle pulse per clockwise detent
//   ROT_DN      out  1       one-cycle pulse per counter-clockwise detent
//   ROT_PRESS   out  1       one-cycle pulse per debounced centre press
//   COARSE      out  1       current step mode, 1 = coarse
// -----------------------------------------------------------------------------
module scope_input_ctrl #(
    parameter int N_BTN       = 4,
    parameter int DEB_BTN     = 50000,
    parameter int DEB_ROT     = 500,
    parameter int CNT_W       = 8,
    parameter int CNT_MAX     = 255,
    parameter int CNT_INIT    = 0,
    parameter int STEP_COARSE = 16,
    parameter int WRAP        = 0
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN,
    input  logic             ROT_A,
    input  logic             ROT_B,
    input  logic             ROT_CENTER,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [CNT_W-1:0] ROT_COUNT,
    output logic             ROT_UP,
    output logic             ROT_DN,
    output logic             ROT_PRESS,
    output logic             COARSE
);

    // Channel map: buttons occupy the low indices, then A, B, centre.
    localparam int NCH     = N_BTN + 3;
    localparam int CH_A    = N_BTN;
    localparam int CH_B    = N_BTN + 1;
    localparam int CH_C    = N_BTN + 2;
    localparam int DEB_MAX = (DEB_BTN > DEB_ROT) ? DEB_BTN : DEB_ROT;
    localparam int DC_W    = $clog2(DEB_MAX + 1);

    localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(CNT_MAX);
    localparam logic [CNT_W:0]   MOD_X  = (CNT_W+1)'(CNT_MAX + 1);
    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP_COARSE);
    localparam logic [CNT_W-1:0] INIT_X = CNT_W'(CNT_INIT);

    generate
        if (CNT_INIT > CNT_MAX || STEP_COARSE > CNT_MAX || CNT_MAX >= (1 << CNT_W)
            || CNT_INIT < 0 || STEP_COARSE < 1) begin : g_param_err
            $error("scope_input_ctrl: CNT_INIT/STEP_COARSE must lie within 0..CNT_MAX, and CNT_MAX must fit CNT_W");
        end
    endgenerate

    // Next count for one detent. Worked one bit wider so an up step past
    // CNT_MAX or a down step below zero is visible before it is clamped/wrapped.
    function automatic logic [CNT_W-1:0] f_step(input logic [CNT_W-1:0] cnt,
                                                input logic             up,
                                                input logic             coarse);
        logic [CNT_W:0] w_s;
        logic [CNT_W:0] w_ext;
        logic [CNT_W:0] w_res;
        w_ext = {1'b0, cnt};
        w_s   = coarse ? STEP_X : (CNT_W+1)'(1);
        if (up) begin
            w_res = w_ext + w_s;
            if (w_res > MAX_X) begin
                w_res = (WRAP != 0) ? (w_res - MOD_X) : MAX_X;
            end
        end else if (w_ext < w_s) begin
            w_res = (WRAP != 0) ? (w_ext + MOD_X - w_s) : '0;
        end else begin
            w_res = w_ext - w_s;
        end
        return w_res[CNT_W-1:0];
    endfunction

    // Reset release synchroniser: assertion is immediate, release lands two
    // edges after RST_N rises, so no flop leaves reset on a metastable edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ---- stage p0/p1: two-flop pad synchroniser ----
    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync_p0;
    logic [NCH-1:0] r_sync_p1;

    assign w_raw = {ROT_CENTER, ROT_B, ROT_A, BTN};

    always_ff @(posedge CLK_50M or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= w_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // ---- stage p2: per-channel debouncer ----
    // The hold counter counts consecutive cycles of disagreement; on the cycle
    // after it reaches the limit (and the input still disagrees) the stable
    // state takes the input. That gives exactly 2+DEB cycles pad-to-state.
    logic [NCH-1:0] w_stable;
    logic [NCH-1:0] w_flip;

    for (genvar g = 0; g < NCH; g++) begin : g_deb
        localparam int              DEB = (g < N_BTN) ? DEB_BTN : DEB_ROT;
        localparam logic [DC_W-1:0] LIM = DC_W'(DEB);

        logic            r_stable;
        logic [DC_W-1:0] r_hold;

        assign w_flip[g]   = (r_sync_p1[g] != r_stable) && (r_hold == LIM);
        assign w_stable[g] = r_stable;

        always_ff @(posedge CLK_50M or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_stable <= 1'b0;
                r_hold   <= '0;
            end else if (w_flip[g]) begin
                r_stable <= r_sync_p1[g];
                r_hold   <= '0;
            end else if (r_sync_p1[g] != r_stable) begin
                r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
        end
    end

    // A flip while the stable state is 0 is a debounced rising edge.
    logic [N_BTN-1:0] w_btn_rise;
    logic             w_a_rise;
    logic             w_c_rise;
    logic             w_up;
    logic             w_dn;

    assign w_btn_rise = w_flip[N_BTN-1:0] & ~w_stable[N_BTN-1:0];
    assign w_a_rise   = w_flip[CH_A] & ~w_stable[CH_A];
    assign w_c_rise   = w_flip[CH_C] & ~w_stable[CH_C];
    assign w_up       = w_a_rise & ~w_stable[CH_B];
    assign w_dn       = w_a_rise &  w_stable[CH_B];

    // ---- stage p3: event pulses, step mode and counter ----
    logic [N_BTN-1:0] r_btn_press;
    logic [CNT_W-1:0] r_count;
    logic             r_up;
    logic             r_dn;
    logic             r_rpress;
    logic             r_coarse;

    always_ff @(posedge CLK_50M or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn_press <= '0;
            r_count     <= INIT_X;
            r_up        <= 1'b0;
            r_dn        <= 1'b0;
            r_rpress    <= 1'b0;
            r_coarse    <= 1'b0;
        end else begin
            r_btn_press <= w_btn_rise;
            r_up        <= w_up;
            r_dn        <= w_dn;
            r_rpress    <= w_c_rise;
            // A detent coinciding with the centre press uses the old mode.
            r_coarse    <= r_coarse ^ w_c_rise;
            if (w_up || w_dn) begin
                r_count <= f_step(r_count, w_up, r_coarse);
            end
        end
    end

    assign BTN_LEVEL = w_stable[N_BTN-1:0];
    assign BTN_PRESS = r_btn_press;
    assign ROT_COUNT = r_count;
    assign ROT_UP    = r_up;
    assign ROT_DN    = r_dn;
    assign ROT_PRESS = r_rpress;
    assign COARSE    = r_coarse;

endmodule

// File: tb/tb_scope_input_ctrl.sv
module tb_scope_input_ctrl;

    localparam int N_BTN   = 4;
    localparam int DEB_BTN = 4;
    localparam int DEB_ROT = 2;
    localparam int CNT_MAX = 9;
    localparam int STEP_C  = 3;
    localparam int NCH     = N_BTN + 3;
    localparam int CH_A    = N_BTN;
    localparam int CH_B    = N_BTN + 1;
    localparam int CH_C    = N_BTN + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = 4'b0;
    logic       rot_a = 1'b0;
    logic       rot_b = 1'b0;
    logic       rot_c = 1'b0;

    logic [3:0] lvl0, prs0, cnt0, lvl1, prs1, cnt1;
    logic       up0, dn0, rp0, co0, up1, dn1, rp1, co1;

    always #5 clk = ~clk;

    scope_input_ctrl #(.N_BTN(4), .DEB_BTN(DEB_BTN), .DEB_ROT(DEB_ROT), .CNT_W(4),
                       .CNT_MAX(CNT_MAX), .CNT_INIT(0), .STEP_COARSE(STEP_C), .WRAP(0)) u_w0 (
        .CLK_50M(clk), .RST_N(rst_n), .BTN(btn), .ROT_A(rot_a), .ROT_B(rot_b),
        .ROT_CENTER(rot_c), .BTN_LEVEL(lvl0), .BTN_PRESS(prs0), .ROT_COUNT(cnt0),
        .ROT_UP(up0), .ROT_DN(dn0), .ROT_PRESS(rp0), .COARSE(co0));

    scope_input_ctrl #(.N_BTN(4), .DEB_BTN(DEB_BTN), .DEB_ROT(DEB_ROT), .CNT_W(4),
                       .CNT_MAX(CNT_MAX), .CNT_INIT(0), .STEP_COARSE(STEP_C), .WRAP(1)) u_w1 (
        .CLK_50M(clk), .RST_N(rst_n), .BTN(btn), .ROT_A(rot_a), .ROT_B(rot_b),
        .ROT_CENTER(rot_c), .BTN_LEVEL(lvl1), .BTN_PRESS(prs1), .ROT_COUNT(cnt1),
        .ROT_UP(up1), .ROT_DN(dn1), .ROT_PRESS(rp1), .COARSE(co1));

    int n_err = 0;
    int n_chk = 0;
    int n_up0 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each channel keeps its recent pad samples (index 0 = this edge). The
    // debouncer at an edge sees the sample from two edges back; the stable
    // state flips once DEB+1 consecutive seen samples all disagree with it.
    bit       hist[NCH][8];
    bit       stab[NCH];
    int       rcnt = 0;
    int       mcnt[2];
    bit       mcoarse;
    bit [3:0] m_press;
    bit       m_up, m_dn, m_rp;

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            stab[c] = 1'b0;
            for (int k = 0; k < 8; k++) hist[c][k] = 1'b0;
        end
        mcnt[0] = 0; mcnt[1] = 0;
        mcoarse = 1'b0; m_press = 4'b0; m_up = 1'b0; m_dn = 1'b0; m_rp = 1'b0;
    endtask

    function automatic int nxt(input int c, input int delta, input bit wrap);
        int v;
        v = c + delta;
        if (wrap) return ((v % (CNT_MAX + 1)) + (CNT_MAX + 1)) % (CNT_MAX + 1);
        if (v > CNT_MAX) return CNT_MAX;
        if (v < 0) return 0;
        return v;
    endfunction

    always @(posedge clk) begin
        bit pad[NCH];
        bit fl[NCH];
        int deb;
        int s;
        if (!rst_n) begin
            rcnt = 0;
            model_clear();
        end else if (rcnt < 2) begin
            rcnt++;
            model_clear();
        end else begin
            for (int i = 0; i < N_BTN; i++) pad[i] = btn[i];
            pad[CH_A] = rot_a; pad[CH_B] = rot_b; pad[CH_C] = rot_c;
            for (int c = 0; c < NCH; c++) begin
                for (int k = 7; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = pad[c];
                deb = (c < N_BTN) ? DEB_BTN : DEB_ROT;
                fl[c] = 1'b1;
                for (int j = 0; j <= deb; j++) if (hist[c][2+j] == stab[c]) fl[c] = 1'b0;
            end
            m_up = fl[CH_A] && !stab[CH_A] && !stab[CH_B];
            m_dn = fl[CH_A] && !stab[CH_A] &&  stab[CH_B];
            s = mcoarse ? STEP_C : 1;
            for (int w = 0; w < 2; w++) begin
                if (m_up) mcnt[w] = nxt(mcnt[w], s, w == 1);
                if (m_dn) mcnt[w] = nxt(mcnt[w], -s, w == 1);
            end
            for (int i = 0; i < N_BTN; i++) m_press[i] = fl[i] && !stab[i];
            m_rp = fl[CH_C] && !stab[CH_C];
            if (m_rp) mcoarse = !mcoarse;
            for (int c = 0; c < NCH; c++) if (fl[c]) stab[c] = !stab[c];
        end
    end

    function automatic logic [15:0] exp_vec(input int w);
        return {stab[3], stab[2], stab[1], stab[0], m_press, 4'(mcnt[w]),
                m_up, m_dn, m_rp, mcoarse};
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #4;
            chk("w0_outputs", int'({lvl0, prs0, cnt0, up0, dn0, rp0, co0}), int'(exp_vec(0)));
            chk("w1_outputs", int'({lvl1, prs1, cnt1, up1, dn1, rp1, co1}), int'(exp_vec(1)));
            chk("w0_updn_excl", int'(up0 & dn0), 0);
            chk("w1_updn_excl", int'(up1 & dn1), 0);
            if (up0) n_up0++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic detent(input bit cw);
        if (cw) begin
            rot_a = 1'b1; cyc(6); rot_b = 1'b1; cyc(6);
            rot_a = 1'b0; cyc(6); rot_b = 1'b0; cyc(6);
        end else begin
            rot_b = 1'b1; cyc(6); rot_a = 1'b1; cyc(6);
            rot_b = 1'b0; cyc(6); rot_a = 1'b0; cyc(6);
        end
    endtask

    task automatic center_press();
        rot_c = 1'b1; cyc(6); rot_c = 1'b0; cyc(6);
    endtask

    initial begin
        int hold[NCH];
        bit pads[NCH];

        #1 rst_n = 1'b0;
        cyc(3);
        chk("rst_level", int'(lvl0), 0);
        chk("rst_press", int'(prs0), 0);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_coarse", int'(co0), 0);
        rst_n = 1'b1;
        cyc(6);

        // Button 0 held: level and press appear on the 6th edge after sampling.
        btn[0] = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 chk("btn0_level_e5", int'(lvl0[0]), 0);
        @(posedge clk);
        #1 chk("btn0_level_e6", int'(lvl0[0]), 1);
        chk("btn0_press_e6", int'(prs0[0]), 1);
        @(posedge clk);
        #1 chk("btn0_press_e7", int'(prs0[0]), 0);
        cyc(1);

        // Three-cycle glitch on button 1 must be ignored.
        btn[1] = 1'b1; cyc(3); btn[1] = 1'b0; cyc(12);
        chk("btn1_glitch_level", int'(lvl0[1]), 0);

        // Saturate vs. wrap with fine steps.
        n_up0 = 0;
        repeat (12) detent(1'b1);
        chk("w0_sat_count", int'(cnt0), 9);
        chk("w0_up_pulses", n_up0, 12);
        chk("w1_wrap_count", int'(cnt1), 2);
        detent(1'b0);
        chk("w0_after_ccw", int'(cnt0), 8);
        chk("w1_after_ccw", int'(cnt1), 1);

        // Reset two cycles into button 2's debounce.
        btn[2] = 1'b1;
        cyc(4);
        rst_n = 1'b0;
        #1 chk("async_rst_level", int'(lvl0), 0);
        chk("async_rst_count_w0", int'(cnt0), 0);
        chk("async_rst_count_w1", int'(cnt1), 0);
        chk("async_rst_coarse", int'(co0), 0);
        cyc(2);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("btn2_press_early", int'(prs0[2]), 0);
        @(posedge clk);
        #1 chk("btn2_press", int'(prs0[2]), 1);
        chk("btn2_level", int'(lvl0[2]), 1);
        @(posedge clk);
        #1 chk("btn2_press_once", int'(prs0[2]), 0);
        cyc(1);

        // Coarse wrap from 8.
        repeat (8) detent(1'b1);
        chk("w1_count_8", int'(cnt1), 8);
        center_press();
        chk("coarse_on", int'(co1), 1);
        detent(1'b1);
        chk("w1_coarse_wrap_up", int'(cnt1), 1);
        chk("w0_coarse_clamp_up", int'(cnt0), 9);
        detent(1'b0);
        chk("w1_coarse_wrap_dn", int'(cnt1), 8);
        chk("w0_coarse_dn", int'(cnt0), 6);

        // Centre press and detent debounce on the same edge.
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(6);
        rot_c = 1'b1; rot_a = 1'b1; cyc(8);
        chk("same_cycle_count", int'(cnt0), 1);
        chk("same_cycle_coarse", int'(co0), 1);
        rot_b = 1'b1; cyc(6); rot_a = 1'b0; cyc(6); rot_b = 1'b0; rot_c = 1'b0; cyc(6);
        detent(1'b1);
        chk("after_toggle_count", int'(cnt0), 4);

        // Random pad activity, including glitches and a reset pulse.
        for (int c = 0; c < NCH; c++) begin
            hold[c] = 0;
            pads[c] = 1'b0;
        end
        for (int i = 0; i < N_BTN; i++) pads[i] = btn[i];
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    if ($urandom_range(1, 0) == 1) pads[c] = !pads[c];
                    hold[c] = $urandom_range(9, 1);
                end else begin
                    hold[c]--;
                end
            end
            for (int i = 0; i < N_BTN; i++) btn[i] = pads[i];
            rot_a = pads[CH_A]; rot_b = pads[CH_B]; rot_c = pads[CH_C];
            if (t == 1500) rst_n = 1'b0;
            if (t == 1503) rst_n = 1'b1;
            cyc(1);
        end
        cyc(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
